serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Sequences a single 1-bit full-adder stage over W cycles to add or subtract two W-bit operands, LSB first.
- Serves as the low-area arithmetic unit for the processor datapath: operands are loaded on a start handshake, bits are shifted through the full-adder stage, and a registered result with flags is presented with a done pulse.

Parameters:
W, 8, operand/result width in bits; legal range W >= 2.
CW, 4, iteration counter width; must satisfy 2^CW > W.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
start  input  1  request; accepted only when ready=1
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  W  operand A, sampled with start
b  input  W  operand B, sampled with start
ready  output  1  high in IDLE; start is accepted at a clk edge where start & ready
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result and flags valid
result  output  W  sum/difference; holds until the next accepted start
carry_out  output  1  final carry out of the MSB; for sub: 1 = no borrow (a >= b unsigned)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset, a synchronous high sample:
  - state=IDLE; counter=0; carry flop=0.
  - Shift registers, result, carry_out and overflow all clear to 0.
  - ready=1, busy=0, done=0.
  - Reset wins over start in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: load sa<=a, sb<=(sub ? ~b : b), carry<=sub, counter<=0, result<=0, carry_out<=0, overflow<=0; go to RUN.
  - With start=0: hold.
- RUN, one bit per cycle:
  - s = sa[0]^sb[0]^carry.
  - c = majority(sa[0], sb[0], carry).
  - result <= {s, result[W-1:1]}; sa, sb shift right by 1; carry <= c.
  - On the iteration where counter==W-2, latch msb_cin <= c; this is the carry into the MSB.
  - On the iteration where counter==W-1:
    - carry_out <= c; overflow <= msb_cin ^ c.
    - Go to DONE.
  - Otherwise counter <= counter+1.
- DONE:
  - done=1 for exactly one cycle; busy=1, ready=0.
  - Unconditionally go to IDLE.
- Latency: start sampled at edge k → RUN occupies edges k+1..k+W → done=1 during the cycle following edge k+W.
  - done is visible W+1 cycles after acceptance; next start can be accepted at edge k+W+2.
- start while busy (RUN/DONE) is ignored, and a, b, sub changes are ignored. No queueing.
- result/carry_out/overflow are registered outputs. They are stable from the done cycle until the next accepted start, which clears them.
- Arithmetic is modulo 2^W; no saturation.
- Reset asserted mid-RUN aborts the operation, with all state per the reset rule above. No done pulse is produced for the aborted operation.

Test Plan:
- W=8, add a=0x35, b=0x4A, start at edge k → done high only in the cycle after edge k+8; result=0x7F, carry_out=0, overflow=0; ready back to 1 the next cycle.
- Add 0xFF+0x01 → result=0x00, carry_out=1, overflow=0. Add 0x7F+0x01 → result=0x80, carry_out=0, overflow=1.
- Sub 0x10-0x20 → result=0xF0, carry_out=0 (borrow), overflow=0. Sub 0x80-0x01 → result=0x7F, carry_out=1, overflow=1.
- Hold start=1 with new operands (0x01, 0x01) during RUN of 0x35+0x4A:
  - Result is still 0x7F.
  - Exactly one done pulse for that operation.
  - The second op starts only when ready=1 is sampled, and then yields 0x02.
- Reset asserted at RUN iteration 4 → next cycle: ready=1, busy=0, result=0, no done pulse. A subsequent start of 0x03+0x04 → result=0x07.
- Back-to-back ops with start held high continuously: done pulses spaced every W+2=10 cycles, each with the correct result.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full-adder stage iterated W times, LSB first.
// Operands load on a start/ready handshake; result and flags are presented with a done pulse.
module serial_adder_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] LAST   = CW'(W-1);
  localparam logic [CW-1:0] PENULT = CW'(W-2);

  state_t        state, state_nxt;
  logic [W-1:0]  sa, sb, res;
  logic [CW-1:0] cnt;
  logic          carry, msb_cin, cout_q, ovf_q;
  logic          s, c;

  // Single full-adder stage on the current LSBs
  assign s = sa[0] ^ sb[0] ^ carry;
  assign c = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready     = (state == IDLE);
  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign result    = res;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      res     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          // Subtract as a + ~b + 1: the +1 enters through the initial carry
          sa     <= a;
          sb     <= sub ? ~b : b;
          carry  <= sub;
          cnt    <= '0;
          res    <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end
        RUN: begin
          res   <= {s, res[W-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= c;
          if (cnt == PENULT) msb_cin <= c;
          if (cnt == LAST) begin
            cout_q <= c;
            ovf_q  <= msb_cin ^ c;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
